// File: rtl/fifo_pkg.sv
// Gray-code helpers shared by the dual-clock FIFO.
// Callers size-cast the 32-bit result down to their own pointer width.
package fifo_pkg;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/cdc_sync_bus.sv
// Multi-flop synchronizer for a Gray-coded bus.
// Only one bit changes per source update, so per-bit resolution is safe.
module cdc_sync_bus #(
  parameter int W      = 1,
  parameter int P_SYNC = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [P_SYNC];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < P_SYNC; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < P_SYNC; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[P_SYNC-1];

endmodule

// File: rtl/async_fifo_gray.sv
// Dual-clock first-word-fall-through FIFO with Gray-coded pointer crossing.
// Used on the RGMII receive path to move bytes from rx_rgmii_clk into mac_clk.
module async_fifo_gray
  import fifo_pkg::*;
#(
  parameter int P_DEPTH = 16,
  parameter int P_WIDTH = 8,
  parameter int P_SYNC  = 2
) (
  input  logic               wr_clk,
  input  logic               wr_rst_n,
  input  logic [P_WIDTH-1:0] wr_data,
  input  logic               wr_vld,
  output logic               wr_rdy,
  input  logic               rd_clk,
  input  logic               rd_rst_n,
  output logic [P_WIDTH-1:0] rd_data,
  output logic               rd_vld,
  input  logic               rd_rdy
);

  localparam int AW = $clog2(P_DEPTH);
  localparam int PW = AW + 1;

  // Handshake: a word moves on the clock edge where vld && rdy are both high;
  // vld never depends on rdy, and an unaccepted push or pop has no effect.

  logic [P_WIDTH-1:0] mem [P_DEPTH];

  // ---------------- write domain ----------------
  logic [PW-1:0] wr_bin;
  logic [PW-1:0] wr_bin_nxt;
  logic [PW-1:0] wr_gray;
  logic [PW-1:0] wr_gray_nxt;
  logic [PW-1:0] rd_gray_s;
  logic          wr_live;
  logic          wr_full;
  logic          wr_push;

  cdc_sync_bus #(.W(PW), .P_SYNC(P_SYNC)) u_rd2wr_sync (
    .clk   (wr_clk),
    .rst_n (wr_rst_n),
    .d     (rd_gray),
    .q     (rd_gray_s)
  );

  // Full when the write pointer is exactly one lap ahead of the read pointer.
  assign wr_full     = (wr_gray == {~rd_gray_s[AW:AW-1], rd_gray_s[AW-2:0]});
  assign wr_rdy      = wr_live && !wr_full;
  assign wr_push     = wr_vld && wr_rdy;
  assign wr_bin_nxt  = wr_bin + {{AW{1'b0}}, wr_push};
  assign wr_gray_nxt = PW'(bin2gray(32'(wr_bin_nxt)));

  // wr_live holds wr_rdy low during reset and for no longer than one edge after.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wr_bin  <= '0;
      wr_gray <= '0;
      wr_live <= 1'b0;
    end else begin
      wr_bin  <= wr_bin_nxt;
      wr_gray <= wr_gray_nxt;
      wr_live <= 1'b1;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (wr_push) begin
      mem[wr_bin[AW-1:0]] <= wr_data;
    end
  end

  // ---------------- read domain ----------------
  logic [PW-1:0] rd_bin;
  logic [PW-1:0] rd_bin_nxt;
  logic [PW-1:0] rd_gray;
  logic [PW-1:0] rd_gray_nxt;
  logic [PW-1:0] wr_gray_s;
  logic          rd_pop;

  cdc_sync_bus #(.W(PW), .P_SYNC(P_SYNC)) u_wr2rd_sync (
    .clk   (rd_clk),
    .rst_n (rd_rst_n),
    .d     (wr_gray),
    .q     (wr_gray_s)
  );

  assign rd_vld      = (rd_gray != wr_gray_s);
  assign rd_pop      = rd_vld && rd_rdy;
  assign rd_bin_nxt  = rd_bin + {{AW{1'b0}}, rd_pop};
  assign rd_gray_nxt = PW'(bin2gray(32'(rd_bin_nxt)));

  // Zeroing the head when empty keeps a stale word from being seen twice.
  assign rd_data = rd_vld ? mem[rd_bin[AW-1:0]] : '0;

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_bin  <= '0;
      rd_gray <= '0;
    end else begin
      rd_bin  <= rd_bin_nxt;
      rd_gray <= rd_gray_nxt;
    end
  end

endmodule

// File: tb/tb_async_fifo_gray.sv
// Directed bench for async_fifo_gray with a queue model checked every read cycle.
`timescale 1ns/1ps
module tb_async_fifo_gray;

  localparam int DEPTH = 16;
  localparam int W     = 8;

  logic         wr_clk = 1'b0;
  logic         rd_clk = 1'b0;
  logic         wr_rst_n = 1'b0;
  logic         rd_rst_n = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         wr_vld = 1'b0;
  logic         wr_rdy;
  logic [W-1:0] rd_data;
  logic         rd_vld;
  logic         rd_rdy = 1'b0;

  real          rd_half = 5.0;

  int           n_vec  = 0;
  int           n_fail = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] popped[$];
  bit           full_seen = 0;

  async_fifo_gray #(.P_DEPTH(DEPTH), .P_WIDTH(W), .P_SYNC(2)) dut (
    .wr_clk   (wr_clk),
    .wr_rst_n (wr_rst_n),
    .wr_data  (wr_data),
    .wr_vld   (wr_vld),
    .wr_rdy   (wr_rdy),
    .rd_clk   (rd_clk),
    .rd_rst_n (rd_rst_n),
    .rd_data  (rd_data),
    .rd_vld   (rd_vld),
    .rd_rdy   (rd_rdy)
  );

  // ---------------- clock / reset ----------------
  initial forever #4 wr_clk = ~wr_clk;
  initial forever #(rd_half) rd_clk = ~rd_clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic report();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
  endtask

  // ---------------- scoreboard ----------------
  // Accepted writes enter the model; wr_rdy must never admit a 17th word.
  always @(negedge wr_clk) begin
    if (wr_rst_n && wr_vld && wr_rdy === 1'b1) begin
      n_vec++;
      if (exp_q.size() >= DEPTH) begin
        n_fail++;
        $display("FAIL overflow: wr_rdy=1 with %0d words held, required 0", exp_q.size());
      end
      exp_q.push_back(wr_data);
    end
  end

  // Head word must match the model whenever rd_vld is high, and be zero otherwise.
  always @(negedge rd_clk) begin
    if (rd_rst_n) begin
      if (rd_vld === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL rd_vld_empty: rd_vld=1 data=%0h, required rd_vld=0", rd_data);
        end else begin
          check("rd_data_head", 32'(rd_data), 32'(exp_q[0]));
          if (rd_rdy) begin
            popped.push_back(rd_data);
            void'(exp_q.pop_front());
          end
        end
      end else begin
        check("rd_vld_known", 32'(rd_vld), 32'd0);
        check("rd_data_zero", 32'(rd_data), 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_rd_rdy(input logic v);
    @(posedge rd_clk);
    #0.5;
    rd_rdy = v;
  endtask

  task automatic reset_both();
    wr_vld   = 1'b0;
    rd_rdy   = 1'b0;
    wr_rst_n = 1'b0;
    rd_rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst_wr_rdy_low", 32'(wr_rdy), 32'd0);
    check("rst_rd_vld", 32'(rd_vld), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    #200;
    @(posedge rd_clk);
    #0.5;
    rd_rst_n = 1'b1;
    @(posedge wr_clk);
    #0.5;
    wr_rst_n = 1'b1;
    @(posedge wr_clk);
    #2;
    check("rel_wr_rdy", 32'(wr_rdy), 32'd1);
    check("rel_rd_vld", 32'(rd_vld), 32'd0);
    check("rel_rd_data", 32'(rd_data), 32'd0);
  endtask

  // Pushes n incrementing words, holding each until it is accepted.
  task automatic stream(input int n, input logic [W-1:0] base);
    int  i = 0;
    int  guard = 0;
    bit  acc;
    @(posedge wr_clk);
    #2;
    while (i < n && guard < 20000) begin
      wr_data = base + W'(i);
      wr_vld  = 1'b1;
      @(negedge wr_clk);
      acc = (wr_rdy === 1'b1);
      if (!acc) full_seen = 1;
      @(posedge wr_clk);
      #2;
      if (acc) i++;
      guard++;
    end
    wr_vld = 1'b0;
    check("stream_accepted", 32'(i), 32'(n));
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 5000) begin
      @(posedge wr_clk);
      guard++;
    end
    repeat (8) @(posedge rd_clk);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_popped_seq(input string name, input int n, input logic [W-1:0] base);
    check({name, "_count"}, 32'(popped.size()), 32'(n));
    for (int i = 0; i < n && i < popped.size(); i++) begin
      check(name, 32'(popped[i]), 32'(base + W'(i)));
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k;

    // Reset from power-up.
    reset_both();

    // Single word fall-through, then pop.
    @(posedge wr_clk);
    #2;
    wr_data = 8'hD5;
    wr_vld  = 1'b1;
    @(posedge wr_clk);
    #2;
    wr_vld = 1'b0;
    k = 0;
    while (rd_vld !== 1'b1 && k < 8) begin
      @(posedge rd_clk);
      #0.5;
      k++;
    end
    check("single_latency_le3", 32'(k <= 3), 32'd1);
    check("single_vld", 32'(rd_vld), 32'd1);
    check("single_data", 32'(rd_data), 32'hD5);
    set_rd_rdy(1'b1);
    set_rd_rdy(1'b0);
    check("single_pop_vld", 32'(rd_vld), 32'd0);
    check("single_pop_data", 32'(rd_data), 32'h00);

    // Fill to capacity, try a 17th write, then drain.
    repeat (6) @(posedge wr_clk);
    check("fill_start_rdy", 32'(wr_rdy), 32'd1);
    stream(DEPTH, 8'h00);
    check("full_wr_rdy", 32'(wr_rdy), 32'd0);
    wr_data = 8'hFF;
    wr_vld  = 1'b1;
    @(posedge wr_clk);
    #2;
    wr_vld = 1'b0;
    check("full_still_low", 32'(wr_rdy), 32'd0);
    popped.delete();
    set_rd_rdy(1'b1);
    wait_drain();
    set_rd_rdy(1'b0);
    check_popped_seq("fill_order", DEPTH, 8'h00);
    repeat (6) @(posedge wr_clk);
    check("drained_wr_rdy", 32'(wr_rdy), 32'd1);

    // Streaming with the nominal ratio, read 3x slower, read 3x faster.
    for (int r = 0; r < 3; r++) begin
      rd_half = (r == 0) ? 5.0 : (r == 1) ? 12.0 : 4.0 / 3.0;
      repeat (4) @(posedge rd_clk);
      full_seen = 0;
      popped.delete();
      set_rd_rdy(1'b1);
      stream(100, 8'h00);
      wait_drain();
      set_rd_rdy(1'b0);
      check_popped_seq("stream_order", 100, 8'h00);
      if (r == 1) check("slow_rd_full_seen", 32'(full_seen), 32'd1);
    end
    rd_half = 5.0;
    repeat (4) @(posedge rd_clk);

    // Reset with five words queued; none may reappear.
    stream(5, 8'hA0);
    repeat (10) @(posedge wr_clk);
    #2;
    check("queued_vld", 32'(rd_vld), 32'd1);
    check("queued_head", 32'(rd_data), 32'hA0);
    reset_both();
    popped.delete();
    set_rd_rdy(1'b1);
    repeat (30) @(posedge rd_clk);
    set_rd_rdy(1'b0);
    check("post_rst_vld", 32'(rd_vld), 32'd0);
    check("post_rst_data", 32'(rd_data), 32'd0);
    check("post_rst_no_words", 32'(popped.size()), 32'd0);

    report();
    $finish;
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached before the sequence ended");
    report();
    $finish;
  end

endmodule
